// File: rtl/mcu_spi_slave.sv
// SPI mode-0 register access responder; SCK/CS_n/MOSI are oversampled in the clk28 domain.
// Define MCU_SPI_AUTOINC_EN to stream further data bytes at auto-incremented addresses.
module mcu_spi_slave (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] status,
    output logic [7:0] addr,
    output logic       addr_valid,
    output logic       rd_stb,
    input  logic [7:0] rd_data,
    output logic       wr_stb,
    output logic [7:0] wdata
);
    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StDone} state_e;

    state_e     state_q;
    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] rx_q;
    logic [7:0] tx_q;
    logic       wr_q;
`ifdef MCU_SPI_AUTOINC_EN
    logic       more_q;
`endif

    logic       sck_rise;
    logic       sck_fall;
    logic       cs_fall;
    logic       cs_high;
    logic       byte_done;
    logic [7:0] rx_byte;

    // CS_n sync resets low so a reset with CS_n held low never fakes a falling edge.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], spi_sck};
            cs_q   <= {cs_q[1:0], spi_cs_n};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_high   = cs_q[1];
    assign rx_byte   = {rx_q, mosi_q[1]};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= 8'hFF;
            wr_q       <= 1'b0;
            spi_miso   <= 1'b1;
            addr       <= '0;
            addr_valid <= 1'b0;
            rd_stb     <= 1'b0;
            wr_stb     <= 1'b0;
            wdata      <= '0;
`ifdef MCU_SPI_AUTOINC_EN
            more_q     <= 1'b0;
`endif
        end else begin
            rd_stb <= 1'b0;
            wr_stb <= 1'b0;
            if (cs_high) begin
                // Abort has priority over any byte completing in the same cycle.
                state_q    <= StIdle;
                bit_cnt_q  <= '0;
                spi_miso   <= 1'b1;
                addr_valid <= 1'b0;
`ifdef MCU_SPI_AUTOINC_EN
                more_q     <= 1'b0;
`endif
            end else if (state_q == StIdle) begin
                if (cs_fall) begin
                    state_q   <= StCmd;
                    bit_cnt_q <= '0;
                    spi_miso  <= status[7];
                    tx_q      <= {status[6:0], 1'b1};
                end
            end else begin
                if (sck_rise) begin
                    rx_q      <= rx_byte[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                if (sck_fall) begin
                    spi_miso <= tx_q[7];
                    tx_q     <= {tx_q[6:0], 1'b1};
                end
                if (rd_stb) begin
                    tx_q <= rd_data;
                end
                // tx_q holds the whole next byte; its MSB goes out on the byte's last fall.
                if (byte_done) begin
                    tx_q <= 8'hFF;
                    case (state_q)
                        StCmd: begin
                            wr_q    <= rx_byte[7];
                            state_q <= StAddr;
                        end
                        StAddr: begin
                            addr       <= rx_byte;
                            addr_valid <= 1'b1;
                            rd_stb     <= ~wr_q;
                            state_q    <= StData;
                        end
                        StData: begin
                            if (wr_q) begin
                                wdata  <= rx_byte;
                                wr_stb <= 1'b1;
                            end
`ifdef MCU_SPI_AUTOINC_EN
                            if (!wr_q || more_q) begin
                                addr <= addr + 8'd1;
                            end
                            if (!wr_q) begin
                                rd_stb <= 1'b1;
                            end
                            more_q <= 1'b1;
`else
                            state_q <= StDone;
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
